// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache memory responder and its storage array.
package cache_mem_pkg;

    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    localparam int LINE_WORDS = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_BURST
    } state_e;

    // Index of the final beat for a read of the given type.
    function automatic logic [1:0] last_beat(input logic [2:0] t);
        case (t)
            TYPE_BYTE, TYPE_HALF, TYPE_WORD: last_beat = 2'd0;
            TYPE_LINE:                       last_beat = 2'(LINE_WORDS - 1);
            default:                         last_beat = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Word-addressed storage: one combinational read port and a four-lane write port
// so a whole line can be written in a single cycle. Contents are never reset.
module cache_mem_array
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                         clk,
    input  logic [ADDR_W-1:0]            rd_idx,
    output logic [31:0]                  rd_data,
    input  logic [ADDR_W-3:0]            wr_line,
    input  logic [LINE_WORDS-1:0]        wr_lane_en,
    input  logic [3:0]                   wr_strb,
    input  logic [32*LINE_WORDS-1:0]     wr_data
);

    logic [31:0] mem [2**ADDR_W];

    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        for (int l = 0; l < LINE_WORDS; l++) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_lane_en[l] && wr_strb[b]) begin
                    mem[{wr_line, 2'(l)}][b*8 +: 8] <= wr_data[l*32 + b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/writeback bus, backed by cache_mem_array.
// Define CACHE_MEM_RDLAT_EN to add RD_LAT wait cycles before the first read beat.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [1:0]         last_q, last_d;
    logic               ret_valid_q, ret_valid_d;
    logic               ret_last_q, ret_last_d;
    logic [31:0]        ret_data_q, ret_data_d;

`ifdef CACHE_MEM_RDLAT_EN
    localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    logic [LAT_W-1:0]   lat_q, lat_d;
`else
    logic [31:0]        unused_rd_lat;
    assign unused_rd_lat = 32'(RD_LAT);
`endif

    logic               idle;
    logic               rd_fire;
    logic               wr_fire;
    logic               wr_is_line;
    logic [1:0]         req_last;
    logic [ADDR_W-1:0]  req_base;
    logic [ADDR_W-1:0]  arr_idx;
    logic [ADDR_W-3:0]  wr_line;
    logic [3:0]         wr_lane_en;
    logic [3:0]         wr_strb_eff;
    logic [31:0]        arr_rdata;
    logic [31:0]        fwd_data;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0],
                                wr_addr[31:ADDR_W+2], wr_addr[1:0]};

    assign idle    = (state_q == S_IDLE);
    assign rd_rdy  = idle;
    assign wr_rdy  = idle;
    assign rd_fire = rd_req && idle;
    assign wr_fire = wr_req && idle;

    assign req_last   = last_beat(rd_type);
    assign req_base   = (rd_type == TYPE_LINE) ? {rd_addr[ADDR_W+1:4], 2'b00}
                                               : rd_addr[ADDR_W+1:2];
    assign wr_is_line = (wr_type == TYPE_LINE);
    assign wr_line    = wr_addr[ADDR_W+1:4];
    assign wr_lane_en = !wr_fire  ? 4'b0000 :
                        wr_is_line ? 4'b1111 : (4'b0001 << wr_addr[3:2]);
    assign wr_strb_eff = wr_is_line ? 4'b1111 : wr_wstrb;

    assign arr_idx = idle ? req_base : base_q + ADDR_W'(cnt_q);

    cache_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk        (clk),
        .rd_idx     (arr_idx),
        .rd_data    (arr_rdata),
        .wr_line    (wr_line),
        .wr_lane_en (wr_lane_en),
        .wr_strb    (wr_strb_eff),
        .wr_data    (wr_data)
    );

    // The first beat is captured on the same edge a simultaneous write commits,
    // so merge the incoming write bytes over the stale array word.
    always_comb begin
        fwd_data = arr_rdata;
        if (wr_line == req_base[ADDR_W-1:2] && wr_lane_en[req_base[1:0]]) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_eff[b]) begin
                    fwd_data[b*8 +: 8] = wr_data[{req_base[1:0], 5'(b*8)} +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        ret_valid_d = 1'b0;
        ret_last_d  = 1'b0;
        ret_data_d  = ret_data_q;
`ifdef CACHE_MEM_RDLAT_EN
        lat_d       = lat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rd_fire) begin
                    base_d = req_base;
                    last_d = req_last;
`ifdef CACHE_MEM_RDLAT_EN
                    if (RD_LAT > 0) begin
                        state_d = S_RD_WAIT;
                        lat_d   = LAT_W'(RD_LAT);
                        cnt_d   = 2'd0;
                    end else
`endif
                    begin
                        state_d     = S_RD_BURST;
                        ret_valid_d = 1'b1;
                        ret_last_d  = (req_last == 2'd0);
                        ret_data_d  = fwd_data;
                        cnt_d       = 2'd1;
                    end
                end
            end
`ifdef CACHE_MEM_RDLAT_EN
            S_RD_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d     = S_RD_BURST;
                    ret_valid_d = 1'b1;
                    ret_last_d  = (last_q == 2'd0);
                    ret_data_d  = arr_rdata;
                    cnt_d       = cnt_q + 2'd1;
                end
            end
`endif
            S_RD_BURST: begin
                if (ret_last_q) begin
                    state_d = S_IDLE;
                end else begin
                    ret_valid_d = 1'b1;
                    ret_last_d  = (cnt_q == last_q);
                    ret_data_d  = arr_rdata;
                    cnt_d       = cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            cnt_q       <= 2'd0;
            last_q      <= 2'd0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_data_q  <= 32'd0;
`ifdef CACHE_MEM_RDLAT_EN
            lat_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            ret_data_q  <= ret_data_d;
`ifdef CACHE_MEM_RDLAT_EN
            lat_q       <= lat_d;
`endif
        end
    end

    assign ret_valid = ret_valid_q;
    assign ret_last  = ret_last_q;
    assign ret_data  = ret_data_q;

endmodule
